// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressable MIPS data memory with synchronous
// reads, byte/half/word access, sign/zero extension on loads, a post-reset
// clear sequencer, alignment/range fault detection and a saturating fault
// counter. The RAM is split into four byte-lane arrays so each lane infers
// its own block RAM with a registered read port. DATA_WIDTH must be 32.
module data_memory_sized #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          MEMORY_DEPTH    = 1024,
    parameter logic [31:0] BASE_ADDRESS    = 32'h1001_0000,
    parameter bit          CLEAR_ON_RESET  = 1'b1,
    parameter int          FAULT_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    input  logic [1:0]                 Size,
    input  logic                       Unsigned,
    input  logic [31:0]                Address,
    input  logic [DATA_WIDTH-1:0]      WriteData,
    output logic                       Ready,
    output logic [DATA_WIDTH-1:0]      ReadData,
    output logic                       ReadValid,
    output logic                       Fault,
    output logic [FAULT_CNT_WIDTH-1:0] FaultCount
);

    localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              clr_idx_q, clr_idx_d;
    logic                       ready_q, ready_d;
    logic                       read_valid_q, read_valid_d;
    logic                       fault_q, fault_d;
    logic [FAULT_CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
    logic                       unsigned_q, unsigned_d;
    logic [1:0]                 size_q, size_d;
    logic [1:0]                 lane_q, lane_d;
    logic [31:0]                hold_q, hold_d;

    logic                       clearing;
    logic [31:0]                offset;
    logic [AW-1:0]              word_idx;
    logic [AW-1:0]              ram_addr;
    logic                       in_range;
    logic                       accept;
    logic                       bad_access;
    logic                       do_fault;
    logic                       do_load;
    logic                       do_store;
    logic [3:0]                 lane_mask;
    logic [31:0]                rd_word;
    logic [31:0]                load_ext;

    // Address decode: offsets below the base wrap to huge values and fall out of range.
    assign offset   = Address - BASE_ADDRESS;
    assign word_idx = offset[AW+1:2];
    assign in_range = ({2'b00, offset[31:2]} < 32'(MEMORY_DEPTH));
    assign ram_addr = clearing ? clr_idx_q : word_idx;

    // Next state for the clear sequencer and the Ready flag.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clearing  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearing = 1'b1;
                if (clr_idx_q == AW'(MEMORY_DEPTH - 1)) begin
                    state_d   = ST_RUN;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Request qualification, fault detection and byte-lane mask.
    always_comb begin
        accept     = ready_q && (MemRead || MemWrite);
        bad_access = (Size == 2'b11)
                  || ((Size == 2'b01) && offset[0])
                  || ((Size == 2'b10) && (offset[1:0] != 2'b00))
                  || !in_range
                  || (MemRead && MemWrite);
        do_fault   = accept && bad_access;
        do_load    = accept && !bad_access && MemRead;
        do_store   = accept && !bad_access && MemWrite;
        case (Size)
            2'b00:   lane_mask = 4'b0001 << offset[1:0];
            2'b01:   lane_mask = offset[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:MEMORY_DEPTH-1];
            logic [7:0] wr_byte;
            logic [7:0] rd_byte_q;
            logic       wr_en;

            // Route the right-justified store data onto this lane.
            always_comb begin
                case (Size)
                    2'b00:   wr_byte = WriteData[7:0];
                    2'b01:   wr_byte = ((gi % 2) == 1) ? WriteData[15:8] : WriteData[7:0];
                    default: wr_byte = WriteData[8*gi +: 8];
                endcase
            end

            assign wr_en = clearing || (do_store && lane_mask[gi]);

            // Lane RAM: write port shared by clear and stores, registered read for loads.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[ram_addr] <= clearing ? 8'h00 : wr_byte;
                end
                if (do_load) begin
                    rd_byte_q <= mem[ram_addr];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

    // Load result selection/extension and the held ReadData value.
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = rd_word[8*lane_q +: 8];
        sel_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   load_ext = unsigned_q ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: load_ext = rd_word;
        endcase
        hold_d = read_valid_q ? load_ext : hold_q;
    end

    // Response pulses, captured load attributes and saturating fault count.
    always_comb begin
        read_valid_d = do_load;
        fault_d      = do_fault;
        unsigned_d   = do_load ? Unsigned       : unsigned_q;
        size_d       = do_load ? Size           : size_q;
        lane_d       = do_load ? offset[1:0]    : lane_q;
        fault_cnt_d  = fault_cnt_q;
        if (do_fault && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + FAULT_CNT_WIDTH'(1);
        end
    end

    // Control state register; reset restarts the clear from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_idx_q    <= '0;
            ready_q      <= 1'b0;
            read_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_cnt_q  <= '0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            ready_q      <= ready_d;
            read_valid_q <= read_valid_d;
            fault_q      <= fault_d;
            fault_cnt_q  <= fault_cnt_d;
            unsigned_q   <= unsigned_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            hold_q       <= hold_d;
        end
    end

    assign Ready      = ready_q;
    assign ReadData   = read_valid_q ? load_ext : hold_q;
    assign ReadValid  = read_valid_q;
    assign Fault      = fault_q;
    assign FaultCount = fault_cnt_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed testbench for data_memory_sized (16 words, 2-bit fault counter).
// Each request pushes its expected response to a scoreboard queue; the
// response is popped and compared one cycle later.
module tb_data_memory_sized;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, Unsigned;
    logic [1:0]  Size;
    logic [31:0] Address, WriteData;
    logic        Ready, ReadValid, Fault;
    logic [31:0] ReadData;
    logic [1:0]  FaultCount;

    data_memory_sized #(
        .DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE),
        .CLEAR_ON_RESET(1'b1), .FAULT_CNT_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
        .Ready(Ready), .ReadData(ReadData), .ReadValid(ReadValid),
        .Fault(Fault), .FaultCount(FaultCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        fault;
        logic [31:0] data;
        logic [1:0]  cnt;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  model [0:4*DEPTH-1];
    logic [1:0]  fcnt;
    logic [31:0] last_rd;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4*DEPTH; i++) model[i] = 8'h00;
        fcnt    = 2'd0;
        last_rd = 32'h0;
    endtask

    // Drive one request, predict its response, then check it after the edge.
    task automatic req(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        exp_t        got;
        logic [31:0] off;
        logic        bad;
        logic [5:0]  b;
        logic [15:0] h;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
        off = addr - BASE;
        bad = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off[1:0] != 2'b00)
           || ((off >> 2) >= 32'(DEPTH)) || (rd && wr);
        b = off[5:0];
        if (bad && fcnt != 2'd3) fcnt = fcnt + 2'd1;
        if (!bad && wr) begin
            case (sz)
                2'b00: model[b] = wd[7:0];
                2'b01: begin model[b] = wd[7:0]; model[b+1] = wd[15:8]; end
                default: for (int k = 0; k < 4; k++) model[b+6'(k)] = wd[8*k +: 8];
            endcase
        end
        if (!bad && rd) begin
            case (sz)
                2'b00: last_rd = uns ? {24'h0, model[b]} : {{24{model[b][7]}}, model[b]};
                2'b01: begin
                    h = {model[b+1], model[b]};
                    last_rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
                end
                default: last_rd = {model[b+3], model[b+2], model[b+1], model[b]};
            endcase
        end
        e.valid = rd && !bad;
        e.fault = bad;
        e.data  = last_rd;
        e.cnt   = fcnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        got = sbq.pop_front();
        chk({tag, ".valid"}, {31'h0, ReadValid}, {31'h0, got.valid});
        chk({tag, ".fault"}, {31'h0, Fault}, {31'h0, got.fault});
        chk({tag, ".data"}, ReadData, got.data);
        chk({tag, ".count"}, {30'h0, FaultCount}, {30'h0, got.cnt});
        $display("req %-12s rd=%0b wr=%0b sz=%0d addr=%h wd=%h -> valid=%0b fault=%0b data=%h cnt=%0d",
                 tag, rd, wr, sz, addr, wd, ReadValid, Fault, ReadData, FaultCount);
    endtask

    task automatic idle_chk(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'h0, ReadValid}, 32'h0);
        chk({tag, ".fault"}, {31'h0, Fault}, 32'h0);
        chk({tag, ".hold"}, ReadData, last_rd);
        $display("idle %-12s data=%h", tag, ReadData);
    endtask

    task automatic reset_outputs_chk(input string tag);
        chk({tag, ".ready"}, {31'h0, Ready}, 32'h0);
        chk({tag, ".valid"}, {31'h0, ReadValid}, 32'h0);
        chk({tag, ".fault"}, {31'h0, Fault}, 32'h0);
        chk({tag, ".data"}, ReadData, 32'h0);
        chk({tag, ".count"}, {30'h0, FaultCount}, 32'h0);
        $display("reset %-12s ready=%0b data=%h cnt=%0d", tag, Ready, ReadData, FaultCount);
    endtask

    // Count cycles until Ready while offering illegal requests that must be ignored.
    task automatic clear_wait(input string tag);
        int   cnt;
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        MemRead = 1'b1; Size = 2'b11; Address = BASE + 32'h2;
        while (cnt < 40 && !Ready) begin
            @(posedge clk);
            #1;
            cnt++;
            seen = seen | Fault;
        end
        MemRead = 1'b0; Size = 2'b00;
        chk({tag, ".cycles"}, 32'(cnt), 32'(DEPTH));
        chk({tag, ".nofault"}, {31'h0, seen}, 32'h0);
        chk({tag, ".count"}, {30'h0, FaultCount}, 32'h0);
        $display("clear %-12s ready after %0d cycles", tag, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00; Unsigned = 1'b0;
        Address = 32'h0; WriteData = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_outputs_chk("por");
        @(negedge clk);
        reset = 1'b1;
        clear_wait("clear1");

        req("ld_zero",  1, 0, 2'b10, 0, BASE + 32'h8, 32'h0);
        req("st_word",  0, 1, 2'b10, 0, BASE + 32'h4, 32'h1122_3344);
        req("st_b5",    0, 1, 2'b00, 0, BASE + 32'h5, 32'h0000_00AB);
        req("st_b6",    0, 1, 2'b00, 0, BASE + 32'h6, 32'h0000_0080);
        req("ld_word4", 1, 0, 2'b10, 0, BASE + 32'h4, 32'h0);
        req("ld_b6s",   1, 0, 2'b00, 0, BASE + 32'h6, 32'h0);
        req("ld_b6u",   1, 0, 2'b00, 1, BASE + 32'h6, 32'h0);
        idle_chk("idle1");
        req("st_half",  0, 1, 2'b01, 0, BASE + 32'h2, 32'h0000_8001);
        req("ld_h2s",   1, 0, 2'b01, 0, BASE + 32'h2, 32'h0);
        req("ld_h2u",   1, 0, 2'b01, 1, BASE + 32'h2, 32'h0);
        req("ld_word0", 1, 0, 2'b10, 0, BASE + 32'h0, 32'h0);
        req("ld_top",   1, 0, 2'b00, 0, BASE + 32'h3F, 32'h0);

        req("f_misal",  1, 0, 2'b10, 0, BASE + 32'h2, 32'h0);
        req("f_below",  0, 1, 2'b10, 0, 32'h1000_FFFC, 32'hDEAD_BEEF);
        req("ld_chk0",  1, 0, 2'b10, 0, BASE + 32'h0, 32'h0);
        req("f_both",   1, 1, 2'b10, 0, BASE + 32'h0, 32'hCAFE_F00D);
        req("f_size",   1, 0, 2'b11, 0, BASE + 32'h0, 32'h0);
        req("f_range",  1, 0, 2'b10, 0, BASE + 32'h40, 32'h0);
        req("f_hmis",   0, 1, 2'b01, 0, BASE + 32'h5, 32'h0000_FFFF);
        req("ld_chk4",  1, 0, 2'b10, 0, BASE + 32'h4, 32'h0);
        idle_chk("idle2");

        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        reset_outputs_chk("async");
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        reset_outputs_chk("midclr");
        @(negedge clk);
        reset = 1'b1;
        clear_wait("clear2");
        req("ld_clr4",  1, 0, 2'b10, 0, BASE + 32'h4, 32'h0);
        req("ld_clr0",  1, 0, 2'b10, 0, BASE + 32'h0, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Next-generation MIPS data memory: byte-addressable RAM behind a configurable base address.
- Supports byte, halfword and word loads and stores with byte-lane writes and sign/zero extension on loads.
- Reads are synchronous: data returns one cycle after the request.
- Adds a post-reset clear sequencer, alignment and range fault detection, and a saturating fault counter.
- Sits between the pipeline MEM stage and the datapath writeback mux.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32 (four byte lanes).
- MEMORY_DEPTH, 1024, number of words stored.
- BASE_ADDRESS, 32'h1001_0000, byte address that maps to word 0.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear sequence.
- FAULT_CNT_WIDTH, 8, width of the fault counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request this cycle.
- MemWrite  in  1  store request this cycle.
- Size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- Unsigned  in  1  1 = zero-extend loads; 0 = sign-extend loads.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- Ready  out  1  1 = requests are accepted this cycle.
- ReadData  out  32  extended load result; valid when ReadValid = 1.
- ReadValid  out  1  one-cycle pulse carrying the load result.
- Fault  out  1  one-cycle pulse on a rejected access.
- FaultCount  out  FAULT_CNT_WIDTH  saturating count of faults.

Behaviour:
- Reset (reset = 0):
  - Ready = 0, ReadData = 0, ReadValid = 0, Fault = 0, FaultCount = 0.
  - FSM goes to CLEAR when CLEAR_ON_RESET = 1, otherwise to RUN.
  - Reset asserted in any state aborts the current activity and restarts from this state; a partial clear restarts from word 0.
- CLEAR state:
  - Internal index counts 0 .. MEMORY_DEPTH-1 and writes one zero word per cycle.
  - Ready = 0 throughout; requests presented during CLEAR are ignored (no fault, no count).
  - After writing the last word, the FSM moves to RUN; Ready = 1 from the next cycle.
  - CLEAR lasts exactly MEMORY_DEPTH cycles after reset release.
- RUN state:
  - A request is accepted when Ready = 1 and (MemRead or MemWrite).
  - MemRead and MemWrite both high in the same cycle is a fault.
- Address mapping:
  - Offset = Address - BASE_ADDRESS, computed modulo 2^32.
  - Word index = Offset[31:2]; lane = Offset[1:0].
- Fault conditions (checked in the cycle the request is accepted):
  - Size = 11.
  - Half access with Offset[0] = 1.
  - Word access with Offset[1:0] != 0.
  - Word index >= MEMORY_DEPTH (this also covers addresses below BASE_ADDRESS, because they wrap to large offsets).
  - MemRead and MemWrite both high.
- On a fault:
  - No RAM write occurs.
  - Fault = 1 in the following cycle; ReadValid stays 0.
  - FaultCount increments by 1 and saturates at all-ones.
- Store:
  - Byte store writes lane Offset[1:0] from WriteData[7:0].
  - Half store writes lanes {Offset[1], 0} and {Offset[1], 1} from WriteData[15:0], little-endian (low byte in the lower lane).
  - Word store writes all four lanes.
  - Untouched lanes keep their contents; the write commits at the accepting edge.
- Load:
  - The RAM word is registered at the accepting edge.
  - In the next cycle, ReadValid = 1 and ReadData holds the selected lanes, extended according to the Unsigned bit as captured at request time.
  - Load latency is 1 cycle; back-to-back loads give a ReadValid pulse on every cycle.
- ReadData holds its last value while ReadValid = 0 and is 0 after reset.
- Read-during-write: a store in cycle N followed by a load of the same word in cycle N+1 returns the new data. A single cycle cannot carry both, because that is a fault.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1, MEMORY_DEPTH = 16 -> Ready = 0 for exactly 16 cycles, then 1; a word load of 0x1001_0008 returns 0x0000_0000 one cycle later with ReadValid = 1.
- Word store 0x1122_3344 at 0x1001_0004, then byte stores 0xAB at offset 0x5 and 0x80 at offset 0x6 -> word load returns 0x1180_AB44. A signed byte load at offset 0x6 returns 0xFFFF_FF80; an unsigned one returns 0x0000_0080.
- Half store 0x8001 at 0x1001_0002, then a signed half load of the same address -> 0xFFFF_8001. The unsigned half load returns 0x0000_8001; lanes 0-1 are unchanged.
- Faults:
  - Word load at 0x1001_0002 -> Fault pulse, no ReadValid, FaultCount = 1.
  - Store to 0x1000_FFFC (below base) -> Fault, memory unchanged, FaultCount = 2.
  - MemRead = MemWrite = 1 -> Fault, FaultCount = 3.
- FAULT_CNT_WIDTH = 2, five faulting requests -> FaultCount sequence 1, 2, 3, 3, 3.
- Reset asserted mid-CLEAR at index 7 -> outputs return to reset values immediately; after release, Ready stays 0 for the full MEMORY_DEPTH cycles again.
